// File: rtl/legv8_ctrl_pkg.sv
// Shared definitions for the LEGv8 control sequencer: opcode constants,
// ALU function-select codes, control-word bit positions, the sequencer state
// enum, the instruction-class enum and a control-word packing helper.
package legv8_ctrl_pkg;

  // 11-bit opcodes, instr[31:21]
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // 10-bit opcodes, instr[31:22]
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  // 8-bit opcodes, instr[31:24]
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  // 6-bit opcode, instr[31:26]
  localparam logic [5:0]  OP_B    = 6'b000101;

  // FS = {func[2:0], Binvert, Ainvert}
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01010;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  // Control-word bit positions
  localparam int CW_SA_LSB   = 20;
  localparam int CW_SB_LSB   = 15;
  localparam int CW_DA_LSB   = 10;
  localparam int CW_REGWRITE = 9;
  localparam int CW_MEMWRITE = 8;
  localparam int CW_FS_LSB   = 3;
  localparam int CW_BSEL     = 2;
  localparam int CW_EN_MEM   = 1;
  localparam int CW_EN_ALU   = 0;

  typedef enum logic [1:0] {FETCH, EXEC, MEMW, HALT} state_e;

  typedef enum logic [3:0] {
    CLS_R, CLS_SHIFT, CLS_IMM, CLS_LDUR, CLS_STUR,
    CLS_CBZ, CLS_CBNZ, CLS_B, CLS_ILLEGAL
  } iclass_e;

  function automatic logic [24:0] pack_cw(
    input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] da,
    input logic rw, input logic mw, input logic [4:0] fs,
    input logic bsel, input logic en_mem, input logic en_alu);
    return {sa, sb, da, rw, mw, fs, bsel, en_mem, en_alu};
  endfunction

endpackage

// File: rtl/legv8_instr_decoder.sv
// Combinational LEGv8 subset decoder.
// Ports:
//   i_instr     - instruction register contents
//   o_cw        - 25-bit datapath control word for the instruction
//   o_constant  - 64-bit immediate for the datapath B input
//   o_br_offset - sign-extended B offset, already scaled by 4
//   o_cb_offset - sign-extended CBZ/CBNZ offset, already scaled by 4
//   o_class     - instruction class
//   o_illegal   - opcode not in the supported subset
module legv8_instr_decoder
  import legv8_ctrl_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [24:0] o_cw,
  output logic [63:0] o_constant,
  output logic [63:0] o_br_offset,
  output logic [63:0] o_cb_offset,
  output iclass_e     o_class,
  output logic        o_illegal
);

  logic [4:0] w_rd;
  logic [4:0] w_rn;
  logic [4:0] w_rm;

  assign w_rd = i_instr[4:0];
  assign w_rn = i_instr[9:5];
  assign w_rm = i_instr[20:16];

  assign o_br_offset = {{36{i_instr[25]}}, i_instr[25:0], 2'b00};
  assign o_cb_offset = {{43{i_instr[23]}}, i_instr[23:5], 2'b00};
  assign o_illegal   = (o_class == CLS_ILLEGAL);

  // Opcode match, widest opcodes first; narrower formats only when no 11-bit match
  always_comb begin
    o_cw       = 25'd0;
    o_constant = 64'd0;
    o_class    = CLS_ILLEGAL;
    case (i_instr[31:21])
      OP_ADD: begin o_class = CLS_R; o_cw = pack_cw(w_rn, w_rm, w_rd, 1'b1, 1'b0, FS_ADD, 1'b0, 1'b0, 1'b1); end
      OP_SUB: begin o_class = CLS_R; o_cw = pack_cw(w_rn, w_rm, w_rd, 1'b1, 1'b0, FS_SUB, 1'b0, 1'b0, 1'b1); end
      OP_AND: begin o_class = CLS_R; o_cw = pack_cw(w_rn, w_rm, w_rd, 1'b1, 1'b0, FS_AND, 1'b0, 1'b0, 1'b1); end
      OP_ORR: begin o_class = CLS_R; o_cw = pack_cw(w_rn, w_rm, w_rd, 1'b1, 1'b0, FS_ORR, 1'b0, 1'b0, 1'b1); end
      OP_EOR: begin o_class = CLS_R; o_cw = pack_cw(w_rn, w_rm, w_rd, 1'b1, 1'b0, FS_EOR, 1'b0, 1'b0, 1'b1); end
      OP_LSL: begin
        o_class    = CLS_SHIFT;
        o_cw       = pack_cw(w_rn, 5'd0, w_rd, 1'b1, 1'b0, FS_LSL, 1'b1, 1'b0, 1'b1);
        o_constant = {58'd0, i_instr[15:10]};
      end
      OP_LSR: begin
        o_class    = CLS_SHIFT;
        o_cw       = pack_cw(w_rn, 5'd0, w_rd, 1'b1, 1'b0, FS_LSR, 1'b1, 1'b0, 1'b1);
        o_constant = {58'd0, i_instr[15:10]};
      end
      // RegWrite is set here; the sequencer masks it until the last memory cycle
      OP_LDUR: begin
        o_class    = CLS_LDUR;
        o_cw       = pack_cw(w_rn, 5'd0, w_rd, 1'b1, 1'b0, FS_ADD, 1'b1, 1'b1, 1'b0);
        o_constant = {{55{i_instr[20]}}, i_instr[20:12]};
      end
      OP_STUR: begin
        o_class    = CLS_STUR;
        o_cw       = pack_cw(w_rn, w_rd, 5'd0, 1'b0, 1'b1, FS_ADD, 1'b1, 1'b0, 1'b0);
        o_constant = {{55{i_instr[20]}}, i_instr[20:12]};
      end
      default: begin
        if (i_instr[31:22] == OP_ADDI) begin
          o_class    = CLS_IMM;
          o_cw       = pack_cw(w_rn, 5'd0, w_rd, 1'b1, 1'b0, FS_ADD, 1'b1, 1'b0, 1'b1);
          o_constant = {52'd0, i_instr[21:10]};
        end else if (i_instr[31:22] == OP_SUBI) begin
          o_class    = CLS_IMM;
          o_cw       = pack_cw(w_rn, 5'd0, w_rd, 1'b1, 1'b0, FS_SUB, 1'b1, 1'b0, 1'b1);
          o_constant = {52'd0, i_instr[21:10]};
        end else if (i_instr[31:24] == OP_CBZ) begin
          o_class = CLS_CBZ;
          o_cw    = pack_cw(w_rd, 5'd0, 5'd0, 1'b0, 1'b0, FS_ADD, 1'b1, 1'b0, 1'b0);
        end else if (i_instr[31:24] == OP_CBNZ) begin
          o_class = CLS_CBNZ;
          o_cw    = pack_cw(w_rd, 5'd0, 5'd0, 1'b0, 1'b0, FS_ADD, 1'b1, 1'b0, 1'b0);
        end else if (i_instr[31:26] == OP_B) begin
          o_class = CLS_B;
        end else begin
          o_class = CLS_ILLEGAL;
        end
      end
    endcase
  end

endmodule

// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 control sequencer: fetches over valid/ready, drives the
// datapath control word and constant, owns the PC.
// Ports:
//   clock, reset          - rising-edge clock, async active-low reset
//   instr, instr_valid    - instruction at pc and its valid flag
//   instr_ready           - unit accepts instr this cycle
//   status                - datapath flags {V,C,N,Z}; only Z is used
//   control_word          - {SA,SB,DA,RegWrite,MemWrite,FS,Bsel,EN_Mem,EN_ALU}
//   constant              - immediate to datapath
//   pc                    - current instruction address
//   illegal               - sticky flag, undecodable opcode seen
module legv8_control_unit
  import legv8_ctrl_pkg::*;
#(
  parameter int          MEM_LATENCY = 2,
  parameter logic [63:0] PC_RESET    = 64'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  status,
  output logic [24:0] control_word,
  output logic [63:0] constant,
  output logic [63:0] pc,
  output logic        illegal
);

  localparam int        CNT_W      = 8;
  localparam bit        LDUR_WAITS = (MEM_LATENCY > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 2);

  state_e            r_state, w_state_nxt;
  logic [63:0]       r_pc, w_pc_nxt, w_pc_target;
  logic [31:0]       r_ir, w_ir_nxt, w_dec_in;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [24:0]       r_cw, w_cw_nxt, w_cw_hold;
  logic [63:0]       r_const, w_const_nxt;
  logic              r_illegal, w_illegal_nxt;
  logic              r_ready;
  logic [24:0]       w_dec_cw;
  logic [63:0]       w_dec_const, w_br_off, w_cb_off;
  iclass_e           w_dec_class;
  logic              w_dec_illegal;
  logic              w_unused_status;

  assign w_unused_status = ^status[3:1];

  // In FETCH the incoming instruction is decoded so the EXEC word can be registered
  assign w_dec_in  = (r_state == FETCH) ? instr : r_ir;
  assign w_cw_hold = w_dec_cw & ~(25'd1 << CW_REGWRITE);

  legv8_instr_decoder u_dec (
    .i_instr     (w_dec_in),
    .o_cw        (w_dec_cw),
    .o_constant  (w_dec_const),
    .o_br_offset (w_br_off),
    .o_cb_offset (w_cb_off),
    .o_class     (w_dec_class),
    .o_illegal   (w_dec_illegal)
  );

  // Next PC at the end of EXEC; Z is sampled here for the conditional branches
  always_comb begin
    w_pc_target = r_pc + 64'd4;
    case (w_dec_class)
      CLS_B:    w_pc_target = r_pc + w_br_off;
      CLS_CBZ:  w_pc_target = status[0]  ? (r_pc + w_cb_off) : (r_pc + 64'd4);
      CLS_CBNZ: w_pc_target = !status[0] ? (r_pc + w_cb_off) : (r_pc + 64'd4);
      default:  w_pc_target = r_pc + 64'd4;
    endcase
  end

  // Sequencer next state and next values of the registered outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_ir_nxt      = r_ir;
    w_cnt_nxt     = r_cnt;
    w_cw_nxt      = 25'd0;
    w_const_nxt   = 64'd0;
    w_illegal_nxt = r_illegal;
    case (r_state)
      FETCH: begin
        if (instr_valid && r_ready) begin
          w_ir_nxt = instr;
          if (w_dec_illegal) begin
            w_state_nxt   = HALT;
            w_illegal_nxt = 1'b1;
          end else begin
            w_state_nxt = EXEC;
            w_const_nxt = w_dec_const;
            w_cw_nxt    = (w_dec_class == CLS_LDUR && LDUR_WAITS) ? w_cw_hold : w_dec_cw;
          end
        end else begin
          w_state_nxt = FETCH;
        end
      end
      EXEC: begin
        if (w_dec_class == CLS_LDUR && LDUR_WAITS) begin
          w_state_nxt = MEMW;
          w_cnt_nxt   = CNT_LOAD;
          w_const_nxt = w_dec_const;
          // RegWrite only in the final MEMW cycle
          w_cw_nxt    = (CNT_LOAD == '0) ? w_dec_cw : w_cw_hold;
        end else begin
          w_state_nxt = FETCH;
          w_pc_nxt    = w_pc_target;
        end
      end
      MEMW: begin
        if (r_cnt == '0) begin
          w_state_nxt = FETCH;
          w_pc_nxt    = r_pc + 64'd4;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
          w_const_nxt = w_dec_const;
          w_cw_nxt    = (r_cnt == CNT_W'(1)) ? w_dec_cw : w_cw_hold;
        end
      end
      HALT: begin
        w_state_nxt   = HALT;
        w_illegal_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  // State, PC, IR, wait counter and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= FETCH;
      r_pc      <= PC_RESET;
      r_ir      <= 32'd0;
      r_cnt     <= '0;
      r_cw      <= 25'd0;
      r_const   <= 64'd0;
      r_illegal <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_ir      <= w_ir_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cw      <= w_cw_nxt;
      r_const   <= w_const_nxt;
      r_illegal <= w_illegal_nxt;
      r_ready   <= (w_state_nxt == FETCH);
    end
  end

  assign instr_ready  = r_ready;
  assign control_word = r_cw;
  assign constant     = r_const;
  assign pc           = r_pc;
  assign illegal      = r_illegal;

endmodule

// File: tb/tb_legv8_control_unit.sv
// Directed testbench for legv8_control_unit with a queue-based scoreboard.
module tb_legv8_control_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  status;
  logic [24:0] control_word;
  logic [63:0] constant;
  logic [63:0] pc;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [24:0] cw;
    logic [63:0] cst;
    logic [63:0] pc_next;
  } exp_t;

  exp_t sb_q[$];

  legv8_control_unit #(.MEM_LATENCY(2), .PC_RESET(64'd0)) dut (
    .clock        (clock),
    .reset        (reset),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .status       (status),
    .control_word (control_word),
    .constant     (constant),
    .pc           (pc),
    .illegal      (illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One non-memory instruction: FETCH handshake, EXEC, back in FETCH
  task automatic run_instr(input string tag, input logic [31:0] ins, input logic [3:0] st,
                           input logic [24:0] ecw, input logic [63:0] ecst, input logic [63:0] epc);
    exp_t e;
    chk({tag, "_ready"}, 64'(instr_ready), 64'd1);
    e.tag = tag; e.cw = ecw; e.cst = ecst; e.pc_next = epc;
    sb_q.push_back(e);
    instr = ins; status = st; instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    e = sb_q.pop_front();
    chk({e.tag, "_cw"}, 64'(control_word), 64'(e.cw));
    chk({e.tag, "_const"}, constant, e.cst);
    @(negedge clock);
    chk({e.tag, "_pc"}, pc, e.pc_next);
    chk({e.tag, "_ready_after"}, 64'(instr_ready), 64'd1);
    chk({e.tag, "_cw_fetch"}, 64'(control_word), 64'd0);
  endtask

  initial begin
    exp_t e;
    reset = 1'b0; instr_valid = 1'b0; instr = 32'd0; status = 4'd0;
    #2;
    chk("rst_pc", pc, 64'd0);
    chk("rst_cw", 64'(control_word), 64'd0);
    chk("rst_const", constant, 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_ready", 64'(instr_ready), 64'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      chk("idle_pc", pc, 64'd0);
      chk("idle_ready", 64'(instr_ready), 64'd1);
      @(negedge clock);
    end

    // ADD X5,X2,X0
    run_instr("add", 32'h8B000045, 4'd0, 25'b0001000000001011001000001, 64'd0, 64'h4);
    // ADDI X1,X0,#4
    run_instr("addi", 32'h91001001, 4'd0, 25'h0000645, 64'd4, 64'h8);

    // LDUR X12,[X0,#-8]: EXEC, one MEMW cycle with RegWrite, then FETCH
    chk("ldur_ready", 64'(instr_ready), 64'd1);
    e.tag = "ldur"; e.cw = 25'h0003046; e.cst = 64'hFFFF_FFFF_FFFF_FFF8; e.pc_next = 64'hC;
    sb_q.push_back(e);
    instr = 32'hF85F800C; instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    e = sb_q.pop_front();
    chk("ldur_exec_cw", 64'(control_word), 64'(e.cw));
    chk("ldur_exec_const", constant, e.cst);
    chk("ldur_exec_pc", pc, 64'h8);
    chk("ldur_exec_ready", 64'(instr_ready), 64'd0);
    @(negedge clock);
    chk("ldur_memw_cw", 64'(control_word), 64'(e.cw | 25'h0000200));
    chk("ldur_memw_const", constant, e.cst);
    chk("ldur_memw_pc", pc, 64'h8);
    @(negedge clock);
    chk("ldur_pc", pc, e.pc_next);
    chk("ldur_ready_after", 64'(instr_ready), 64'd1);
    chk("ldur_cw_fetch", 64'(control_word), 64'd0);

    // B +1, CBZ taken, B -3 back, CBZ not taken, STUR, LSL, CBNZ taken backwards
    run_instr("b_fwd", 32'h14000001, 4'd0, 25'd0, 64'd0, 64'h10);
    run_instr("cbz_taken", 32'hB4000063, 4'b0001, 25'h0300044, 64'd0, 64'h1C);
    run_instr("b_back", 32'h17FFFFFD, 4'd0, 25'd0, 64'd0, 64'h10);
    run_instr("cbz_not", 32'hB4000063, 4'b0000, 25'h0300044, 64'd0, 64'h14);
    run_instr("stur", 32'hF8010047, 4'd0, 25'h0238144, 64'd16, 64'h18);
    run_instr("lsl", 32'hD3601483, 4'd0, 25'h0400E85, 64'd5, 64'h1C);
    run_instr("cbnz_taken", 32'hB5FFFFE3, 4'b0000, 25'h0300044, 64'd0, 64'h18);

    // Undecodable opcode: HALT is sticky and ignores further valid instructions
    instr = 32'h00000000; instr_valid = 1'b1;
    @(negedge clock);
    instr = 32'h8B000045;
    for (int i = 0; i < 5; i++) begin
      chk("halt_illegal", 64'(illegal), 64'd1);
      chk("halt_ready", 64'(instr_ready), 64'd0);
      chk("halt_cw", 64'(control_word), 64'd0);
      chk("halt_pc", pc, 64'h18);
      @(negedge clock);
    end
    instr_valid = 1'b0;

    // Reset returns everything to reset values, including the sticky flag
    reset = 1'b0;
    #1;
    chk("rst2_illegal", 64'(illegal), 64'd0);
    chk("rst2_pc", pc, 64'd0);
    chk("rst2_ready", 64'(instr_ready), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Reset in the middle of the LDUR memory wait
    instr = 32'hF85F800C; instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    chk("ldur2_exec_cw", 64'(control_word), 64'h3046);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("midmemw_cw", 64'(control_word), 64'd0);
    chk("midmemw_const", constant, 64'd0);
    chk("midmemw_pc", pc, 64'd0);
    chk("midmemw_ready", 64'(instr_ready), 64'd0);
    @(negedge clock);
    chk("midmemw_regwrite", 64'(control_word[9]), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("post_pc", pc, 64'd0);
    chk("post_ready", 64'(instr_ready), 64'd1);
    chk("post_cw", 64'(control_word), 64'd0);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
